// File: rtl/vend_dispense_sequencer.sv
// vend_dispense_sequencer: drives the slot motor for a validated purchase,
// tracks per-slot stock, then pays out change greedily as a series of
// bill-dispenser handshakes and reports completion with a fault code.
module vend_dispense_sequencer #(
   parameter int unsigned NUM_SLOTS     = 8,
   parameter int unsigned STOCK_INIT    = 5,
   parameter int unsigned MOTOR_TIMEOUT = 1000,
   parameter int unsigned DENOM0        = 20,
   parameter int unsigned DENOM1        = 10,
   parameter int unsigned DENOM2        = 5,
   parameter int unsigned DENOM3        = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [3:0]           slot,
   input  logic [11:0]          paid,
   input  logic [11:0]          refund,
   input  logic                 restock_en,
   input  logic [3:0]           restock_slot,
   input  logic [3:0]           restock_qty,
   output logic                 motor_req,
   output logic [3:0]           motor_slot,
   input  logic                 motor_done,
   output logic                 pay_req,
   output logic [1:0]           pay_denom,
   input  logic                 pay_ack,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           fault,
   output logic [NUM_SLOTS-1:0] empty_mask
);

   localparam int unsigned TW = (MOTOR_TIMEOUT > 1) ? $clog2(MOTOR_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(MOTOR_TIMEOUT - 1);
   localparam logic [4:0]    NSLOT    = 5'(NUM_SLOTS);
   localparam logic [3:0]    SINIT    = 4'(STOCK_INIT);
   localparam logic [11:0]   D0       = 12'(DENOM0);
   localparam logic [11:0]   D1       = 12'(DENOM1);
   localparam logic [11:0]   D2       = 12'(DENOM2);
   localparam logic [11:0]   D3       = 12'(DENOM3);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_VEND, S_CHANGE_SEL, S_PAY
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    slot_q, slot_d;
   logic [11:0]   paid_q, paid_d;
   logic [11:0]   refund_q, refund_d;
   logic [11:0]   remaining_q, remaining_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          motor_req_q, motor_req_d;
   logic [3:0]    motor_slot_q, motor_slot_d;
   logic          pay_req_q, pay_req_d;
   logic [1:0]    pay_denom_q, pay_denom_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [1:0]    fault_q, fault_d;
   logic [3:0]    stock_q [NUM_SLOTS];
   logic [3:0]    stock_d [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] empty_mask_q, empty_mask_d;

   logic [3:0]    slot_stock;
   logic          slot_ok;
   logic [11:0]   denom_val;
   logic [1:0]    denom_sel;

   // Next-state, stock update and change-selection logic.
   always_comb begin
      state_d      = state_q;
      slot_d       = slot_q;
      paid_d       = paid_q;
      refund_d     = refund_q;
      remaining_d  = remaining_q;
      tmo_d        = tmo_q;
      motor_req_d  = motor_req_q;
      motor_slot_d = motor_slot_q;
      pay_req_d    = pay_req_q;
      pay_denom_d  = pay_denom_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      fault_d      = fault_q;
      stock_d      = stock_q;

      slot_ok    = ({1'b0, slot_q} < NSLOT);
      slot_stock = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         empty_mask_d[i] = (stock_q[i] == 4'd0);
         if (slot_q == 4'(i)) slot_stock = stock_q[i];
      end

      case (pay_denom_q)
         2'd0:    denom_val = D0;
         2'd1:    denom_val = D1;
         2'd2:    denom_val = D2;
         default: denom_val = D3;
      endcase

      if (remaining_q >= D0)      denom_sel = 2'd0;
      else if (remaining_q >= D1) denom_sel = 2'd1;
      else if (remaining_q >= D2) denom_sel = 2'd2;
      else                        denom_sel = 2'd3;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               slot_d   = slot;
               paid_d   = paid;
               refund_d = refund;
               busy_d   = 1'b1;
               fault_d  = 2'b00;
               state_d  = S_CHECK;
            end else if (restock_en && ({1'b0, restock_slot} < NSLOT)) begin
               for (int unsigned i = 0; i < NUM_SLOTS; i++)
                  if (restock_slot == 4'(i)) stock_d[i] = restock_qty;
            end
         end
         S_CHECK: begin
            if (!slot_ok) begin
               remaining_d = paid_q;
               fault_d     = 2'b11;
               state_d     = S_CHANGE_SEL;
            end else if (slot_stock == 4'd0) begin
               remaining_d = paid_q;
               fault_d     = 2'b01;
               state_d     = S_CHANGE_SEL;
            end else begin
               motor_req_d  = 1'b1;
               motor_slot_d = slot_q;
               tmo_d        = '0;
               state_d      = S_VEND;
            end
         end
         S_VEND: begin
            // motor_done is checked before the timeout so a done on the final cycle wins
            if (motor_done) begin
               motor_req_d = 1'b0;
               for (int unsigned i = 0; i < NUM_SLOTS; i++)
                  if (slot_q == 4'(i)) stock_d[i] = stock_q[i] - 4'd1;
               remaining_d = refund_q;
               state_d     = S_CHANGE_SEL;
            end else if (tmo_q == TMO_LAST) begin
               motor_req_d = 1'b0;
               remaining_d = paid_q;
               fault_d     = 2'b10;
               state_d     = S_CHANGE_SEL;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_CHANGE_SEL: begin
            if (remaining_q == 12'd0) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               pay_denom_d = denom_sel;
               pay_req_d   = 1'b1;
               state_d     = S_PAY;
            end
         end
         S_PAY: begin
            if (pay_ack) begin
               pay_req_d   = 1'b0;
               remaining_d = remaining_q - denom_val;
               state_d     = S_CHANGE_SEL;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, handshake outputs and stock registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         slot_q       <= '0;
         paid_q       <= '0;
         refund_q     <= '0;
         remaining_q  <= '0;
         tmo_q        <= '0;
         motor_req_q  <= 1'b0;
         motor_slot_q <= '0;
         pay_req_q    <= 1'b0;
         pay_denom_q  <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fault_q      <= 2'b00;
         for (int unsigned i = 0; i < NUM_SLOTS; i++) stock_q[i] <= SINIT;
         empty_mask_q <= {NUM_SLOTS{STOCK_INIT == 0}};
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         paid_q       <= paid_d;
         refund_q     <= refund_d;
         remaining_q  <= remaining_d;
         tmo_q        <= tmo_d;
         motor_req_q  <= motor_req_d;
         motor_slot_q <= motor_slot_d;
         pay_req_q    <= pay_req_d;
         pay_denom_q  <= pay_denom_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         fault_q      <= fault_d;
         stock_q      <= stock_d;
         empty_mask_q <= empty_mask_d;
      end
   end

   assign motor_req  = motor_req_q;
   assign motor_slot = motor_slot_q;
   assign pay_req    = pay_req_q;
   assign pay_denom  = pay_denom_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign fault      = fault_q;
   assign empty_mask = empty_mask_q;

endmodule

// File: doc/vend_dispense_sequencer.md
# vend_dispense_sequencer

Sequences the physical vend after a purchase is validated. It drives the slot motor with a request/done handshake and a timeout, and tracks per-slot stock. It then pays out change as a greedy series of bill-dispenser handshakes and reports completion with a fault code. It sits between the purchase controller, which supplies slot, paid and refund amounts, and the motor and bill-dispenser drivers.

## Interface
- NUM_SLOTS, 8, number of product slots (1..16)
- STOCK_INIT, 5, per-slot stock count loaded at reset (0..15)
- MOTOR_TIMEOUT, 1000, maximum cycles motor_req stays high without motor_done
- DENOM0/1/2/3, 20/10/5/1, bill values for pay_denom 0..3; strictly descending, DENOM3 must be 1
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to vend; sampled only when busy=0
- slot  in  4  slot index, captured with start
- paid  in  12  amount inserted (binary, 0..999), captured with start
- refund  in  12  change owed on successful vend (binary, ≤ paid), captured with start
- restock_en  in  1  load stock for restock_slot; honoured only when busy=0 and start=0
- restock_slot  in  4  slot to restock
- restock_qty  in  4  new stock count
- motor_req  out  1  drive the slot motor; held until motor_done or timeout
- motor_slot  out  4  slot being driven; valid while motor_req=1
- motor_done  in  1  motor cycle complete; sampled only while motor_req=1
- pay_req  out  1  dispense one bill; held until pay_ack
- pay_denom  out  2  bill select; stable while pay_req=1
- pay_ack  in  1  bill dispensed; sampled only while pay_req=1
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- fault  out  2  00 ok, 01 slot empty, 10 motor timeout, 11 bad slot; valid with done, held until next start
- empty_mask  out  NUM_SLOTS  bit i=1 when stock[i]==0

## Operation
- States: IDLE, CHECK, VEND, CHANGE_SEL, PAY, with the transitions below.
- IDLE
  - start=1: capture slot, paid and refund; set busy=1; clear fault; go to CHECK.
- CHECK
  - slot ≥ NUM_SLOTS: remaining=paid, fault=11, go to CHANGE_SEL.
  - Otherwise stock[slot]==0: remaining=paid, fault=01, go to CHANGE_SEL.
  - Otherwise: motor_req=1, motor_slot=slot, clear the timeout counter, go to VEND.
- VEND
  - motor_done=1: motor_req=0, stock[slot] decrements by 1, remaining=refund, go to CHANGE_SEL.
  - Otherwise, if motor_req has been high for MOTOR_TIMEOUT cycles: motor_req=0, stock unchanged, remaining=paid, fault=10, go to CHANGE_SEL.
  - motor_done on the final timeout cycle counts as success.
- CHANGE_SEL
  - remaining==0: done=1 for one cycle, busy=0, go to IDLE.
  - Otherwise: select the largest DENOMk ≤ remaining, set pay_denom=k and pay_req=1, go to PAY.
- PAY
  - pay_ack=1: pay_req=0, remaining -= DENOMk, go to CHANGE_SEL.
  - pay_req therefore goes low for at least one cycle between bills.
- Arithmetic
  - remaining is 12-bit unsigned and never underflows, because DENOMk ≤ remaining.
  - Worst case is 999 with default denominations: 49×20 + 10 + 5 + 4×1 = 55 bills.
- Stock
  - Stock counters are 4-bit.
  - A restock_en with an out-of-range slot is ignored.
  - Restock while busy=1 is ignored.
  - start and restock_en asserted together: start wins and the restock is dropped.
- empty_mask is registered from the stock array and updates one cycle after any stock change.
- start while busy=1 is ignored with no queuing.

## Timing
- Reset values
  - State IDLE.
  - motor_req=0, pay_req=0, busy=0, done=0, fault=00, motor_slot=0, pay_denom=0.
  - All stock counters = STOCK_INIT.
  - empty_mask = all 1 if STOCK_INIT==0, else all 0.
- Reset taking effect mid-sequence
  - Outputs return to reset values on the next edge.
  - Any in-flight motor or bill handshake is abandoned, with no done pulse.
- Edge-by-edge sequence
  - E0: start sampled. After E0, busy=1.
  - E1: CHECK decides. After E1, motor_req=1.
  - Ek: motor_done sampled. After Ek, motor_req=0.
  - Ek+1: first pay_req=1, or done=1 if refund==0.
- Per-bill cost: 1 cycle select + 1 cycle wait minimum with ack same cycle, so 2 cycles per bill.
- done and busy=0 assert in the same cycle. A new start is accepted the cycle after done.
- Fault path with no motor: E0 start, E1 CHECK, first pay_req after E2.

## Test plan
- Normal vend and change: slot=3, paid=100, refund=37, motor_done 4 cycles after motor_req → pay_denom sequence 0,1,2,3,3 (20,10,5,1,1); stock[3] goes 5→4; done with fault=00.
- Empty slot: restock slot 2 qty 0, then start slot=2, paid=120 → empty_mask[2]=1; no motor_req; six bills of denom 0; fault=01; stock unchanged.
- Motor timeout: MOTOR_TIMEOUT=16, motor_done held 0, paid=45, refund=5 → motor_req high exactly 16 cycles; bills 20,20,5; fault=10; stock unchanged.
- Bad slot and zero change: slot=9, paid=0 → no motor_req, no pay_req, done 2 cycles after start with fault=11. Separately, a valid slot with refund=0 gives done the cycle after the motor_done edge.
- Busy protection: second start and a restock_en during PAY → both ignored, and captured refund is unaffected. Also: pay_ack held low for 50 cycles → pay_req stays high with pay_denom stable.
- Reset mid-sequence: reset=0 while pay_req=1 after a vend → next cycle pay_req=0, busy=0, no done pulse, all stock=STOCK_INIT, fault=00.
